// File: rtl/memory_checker.sv
// memory_checker: sweeps addresses 0..LAST_ADDR over a read-only memory port
// and checks each byte against the incrementing pattern (expected = A[7:0]).
// Latency: one read per cycle; a full pass takes LAST_ADDR+3 cycles from the
// start edge to odone=1. No backpressure: the memory must answer every read
// exactly one cycle after the read strobe.
//
// Ports:
//   iclk            clock, all state changes on the rising edge
//   irst            asynchronous active-low reset
//   istart          request a pass (honoured only in IDLE or DONE)
//   idata           read data, valid the cycle after a cycle with oread=1
//   oaddr / oread   read address and strobe
//   obusy / odone   pass in progress / pass finished (held until next start)
//   opass           meaningful while odone=1; 1 when no mismatch was seen
//   oerr_count      saturating mismatch counter
//   ofirst_err_addr / ofirst_err_data  address and data of the first mismatch
module memory_checker #(
  parameter logic [15:0] LAST_ADDR   = 16'hFFFF,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [7:0]  idata,
  output logic [15:0] oaddr,
  output logic        oread,
  output logic        obusy,
  output logic        odone,
  output logic        opass,
  output logic [15:0] oerr_count,
  output logic [15:0] ofirst_err_addr,
  output logic [7:0]  ofirst_err_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READING = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] addr_nxt;
  logic        read_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        pass_nxt;
  logic [15:0] err_nxt;
  logic [15:0] ferr_addr_nxt;
  logic [7:0]  ferr_data_nxt;

  // One-deep pipeline: address of the read whose data is on idata now.
  logic [15:0] paddr, paddr_nxt;
  logic        pvalid, pvalid_nxt;

  logic        mismatch;

  assign mismatch = pvalid && (idata != paddr[7:0]);

  always_comb begin
    state_nxt     = state;
    addr_nxt      = oaddr;
    read_nxt      = oread;
    busy_nxt      = obusy;
    done_nxt      = odone;
    pass_nxt      = opass;
    err_nxt       = oerr_count;
    ferr_addr_nxt = ofirst_err_addr;
    ferr_data_nxt = ofirst_err_data;
    paddr_nxt     = paddr;
    pvalid_nxt    = 1'b0;

    // Error bookkeeping happens in whichever state the compare lands in
    // (READING or DRAIN). A zero count means no mismatch yet this pass,
    // since the counter saturates instead of wrapping back to zero.
    if (mismatch) begin
      if (oerr_count != 16'hFFFF) begin
        err_nxt = oerr_count + 16'd1;
      end
      if (oerr_count == 16'd0) begin
        ferr_addr_nxt = paddr;
        ferr_data_nxt = idata;
      end
    end

    case (state)
      IDLE, DONE: begin
        if (istart) begin
          state_nxt     = READING;
          addr_nxt      = 16'd0;
          read_nxt      = 1'b1;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          err_nxt       = 16'd0;
          ferr_addr_nxt = 16'd0;
          ferr_data_nxt = 8'd0;
        end
      end

      READING: begin
        // The address on oaddr this cycle is being read; remember it so the
        // data returning next cycle can be checked against it.
        paddr_nxt  = oaddr;
        pvalid_nxt = 1'b1;
        if (oaddr == LAST_ADDR) begin
          state_nxt = DRAIN;
          read_nxt  = 1'b0;
        end else begin
          addr_nxt = oaddr + 16'd1;
        end
        // Early stop: the read issued this cycle is abandoned, so its data
        // is never compared and oaddr stays on the last issued address.
        if (STOP_ON_ERR && mismatch) begin
          state_nxt  = DONE;
          addr_nxt   = oaddr;
          read_nxt   = 1'b0;
          pvalid_nxt = 1'b0;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          pass_nxt   = 1'b0;
        end
      end

      DRAIN: begin
        // Last compare is happening this cycle; fold it into opass.
        state_nxt = DONE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        pass_nxt  = (err_nxt == 16'd0);
      end

      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state           <= IDLE;
      oaddr           <= 16'd0;
      oread           <= 1'b0;
      obusy           <= 1'b0;
      odone           <= 1'b0;
      opass           <= 1'b0;
      oerr_count      <= 16'd0;
      ofirst_err_addr <= 16'd0;
      ofirst_err_data <= 8'd0;
      paddr           <= 16'd0;
      pvalid          <= 1'b0;
    end else begin
      state           <= state_nxt;
      oaddr           <= addr_nxt;
      oread           <= read_nxt;
      obusy           <= busy_nxt;
      odone           <= done_nxt;
      opass           <= pass_nxt;
      oerr_count      <= err_nxt;
      ofirst_err_addr <= ferr_addr_nxt;
      ofirst_err_data <= ferr_data_nxt;
      paddr           <= paddr_nxt;
      pvalid          <= pvalid_nxt;
    end
  end

endmodule

// File: tb/tb_memory_checker.sv
// Scoreboard bench for memory_checker: four instances with different
// LAST_ADDR / STOP_ON_ERR settings, each backed by its own memory model.
// Expected pass results are queued at stimulus time and checked when odone rises.
module tb_memory_checker;

  localparam int NI = 4;

  typedef struct {
    logic [15:0] errs;
    logic [15:0] faddr;
    logic [7:0]  fdata;
    logic        pass;
    int          cycles;
    int          reads;
  } exp_t;

  logic        iclk = 1'b0;
  logic        irst;
  logic        istart          [NI];
  logic [15:0] oaddr           [NI];
  logic        oread           [NI];
  logic        obusy           [NI];
  logic        odone           [NI];
  logic        opass           [NI];
  logic [15:0] oerr_count      [NI];
  logic [15:0] ofirst_err_addr [NI];
  logic [7:0]  ofirst_err_data [NI];

  logic [7:0]  mem [NI][512];
  exp_t        exp_q [NI][$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 iclk = ~iclk;

  function automatic logic [15:0] last_of(int i);
    case (i)
      0, 1:    return 16'h000F;
      2:       return 16'h0000;
      default: return 16'h01FF;
    endcase
  endfunction

  function automatic exp_t mk(logic [15:0] e, logic [15:0] fa, logic [7:0] fd,
                              logic p, int c, int r);
    exp_t x;
    x.errs = e; x.faddr = fa; x.fdata = fd; x.pass = p; x.cycles = c; x.reads = r;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] rdat;

    memory_checker #(
      .LAST_ADDR   (last_of(g)),
      .STOP_ON_ERR (g == 1)
    ) u_dut (
      .iclk            (iclk),
      .irst            (irst),
      .istart          (istart[g]),
      .idata           (rdat),
      .oaddr           (oaddr[g]),
      .oread           (oread[g]),
      .obusy           (obusy[g]),
      .odone           (odone[g]),
      .opass           (opass[g]),
      .oerr_count      (oerr_count[g]),
      .ofirst_err_addr (ofirst_err_addr[g]),
      .ofirst_err_data (ofirst_err_data[g])
    );

    // Synchronous-read memory; a filler value appears when no read is
    // pending so stray compares would show up as extra errors.
    always @(posedge iclk) begin
      if (oread[g]) rdat <= mem[g][oaddr[g][8:0]];
      else          rdat <= 8'h3C;
    end
  end

  // Monitor: address sequence on every read, results whenever odone rises.
  initial begin
    int   cyc;
    int   st [NI];
    int   rd [NI];
    logic bq [NI];
    logic dq [NI];
    exp_t e;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      st[i] = 0; rd[i] = 0; bq[i] = 1'b0; dq[i] = 1'b0;
    end
    forever begin
      @(negedge iclk);
      for (int i = 0; i < NI; i++) begin
        if (obusy[i] === 1'b1 && bq[i] !== 1'b1) begin
          st[i] = cyc;
          rd[i] = 0;
        end
        if (oread[i] === 1'b1) begin
          chk($sformatf("i%0d_read_addr", i), 64'(oaddr[i]), 64'(rd[i]));
          rd[i]++;
        end
        if (odone[i] === 1'b1 && dq[i] !== 1'b1) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL i%0d_unexpected_done: odone rose with no pass expected", i);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("i%0d_err_count", i), 64'(oerr_count[i]), 64'(e.errs));
            chk($sformatf("i%0d_first_addr", i), 64'(ofirst_err_addr[i]), 64'(e.faddr));
            chk($sformatf("i%0d_first_data", i), 64'(ofirst_err_data[i]), 64'(e.fdata));
            chk($sformatf("i%0d_opass", i), 64'(opass[i]), 64'(e.pass));
            chk($sformatf("i%0d_cycles", i), 64'(cyc - st[i] + 1), 64'(e.cycles));
            chk($sformatf("i%0d_reads", i), 64'(rd[i]), 64'(e.reads));
            chk($sformatf("i%0d_done_busy_read", i), {obusy[i], oread[i]}, 64'd0);
          end
        end
        bq[i] = obusy[i];
        dq[i] = odone[i];
      end
      cyc++;
    end
  end

  task automatic start_pass(int i, logic push, exp_t e);
    @(negedge iclk);
    istart[i] = 1'b1;
    if (push) exp_q[i].push_back(e);
    @(negedge iclk);
    istart[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget);
    int n;
    n = 0;
    while (odone[i] !== 1'b1 && n < budget) begin
      @(negedge iclk);
      n++;
    end
    if (odone[i] !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL i%0d_done_timeout: odone=%b after %0d cycles, required 1", i, odone[i], n);
    end
  endtask

  task automatic chk_cleared(string name, int i);
    chk(name, {oaddr[i], oread[i], obusy[i], odone[i], opass[i], oerr_count[i],
               ofirst_err_addr[i], ofirst_err_data[i]}, 64'd0);
  endtask

  initial begin
    exp_t clean;
    int   n;
    irst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      istart[i] = 1'b0;
      for (int a = 0; a < 512; a++) mem[i][a] = (i == 3) ? 8'hFF : 8'(a);
    end
    clean = mk(16'd0, 16'd0, 8'd0, 1'b1, 18, 16);

    #3 irst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk_cleared($sformatf("i%0d_reset_state", i), i);
    repeat (2) @(negedge iclk);
    irst = 1'b1;
    repeat (2) @(negedge iclk);

    // Clean pass, LAST_ADDR=F
    start_pass(0, 1'b1, clean);
    wait_done(0, 40);

    // Two corrupted bytes, counting mode
    mem[0][5] = 8'hAA;
    mem[0][9] = 8'h00;
    start_pass(0, 1'b1, mk(16'd2, 16'd5, 8'hAA, 1'b0, 18, 16));
    wait_done(0, 40);

    // Same corruption, stop at first mismatch: reads 0..6 only
    mem[1][5] = 8'hAA;
    mem[1][9] = 8'h00;
    start_pass(1, 1'b1, mk(16'd1, 16'd5, 8'hAA, 1'b0, 8, 7));
    wait_done(1, 40);

    // Single-address pass, clean then corrupted
    start_pass(2, 1'b1, mk(16'd0, 16'd0, 8'd0, 1'b1, 3, 1));
    wait_done(2, 10);
    mem[2][0] = 8'h07;
    start_pass(2, 1'b1, mk(16'd1, 16'd0, 8'h07, 1'b0, 3, 1));
    wait_done(2, 10);

    // All-FF memory over 512 addresses: only 0xFF and 0x1FF match
    start_pass(3, 1'b1, mk(16'h01FE, 16'd0, 8'hFF, 1'b0, 514, 512));
    wait_done(3, 600);

    // istart held high from DONE (with stale errors): no restart mid-pass,
    // immediate restart on the first DONE cycle.
    mem[0][5] = 8'h05;
    mem[0][9] = 8'h09;
    @(negedge iclk);
    istart[0] = 1'b1;
    exp_q[0].push_back(clean);
    exp_q[0].push_back(clean);
    @(negedge iclk);
    wait_done(0, 40);
    @(negedge iclk);
    chk("held_start_restart", {odone[0], obusy[0], oread[0], oaddr[0]}, {3'b011, 16'd0});
    istart[0] = 1'b0;
    wait_done(0, 40);

    // Reset in the middle of a pass at address 7
    start_pass(0, 1'b0, clean);
    n = 0;
    while (!(oread[0] === 1'b1 && oaddr[0] == 16'd7) && n < 40) begin
      @(negedge iclk);
      n++;
    end
    chk("reached_addr7", 64'(oaddr[0]), 64'd7);
    #2 irst = 1'b0;
    #1 chk_cleared("async_reset_midpass", 0);
    @(negedge iclk);
    irst = 1'b1;
    repeat (3) @(negedge iclk);
    chk("idle_after_reset", {obusy[0], oread[0], odone[0], oaddr[0]}, 64'd0);
    start_pass(0, 1'b1, clean);
    wait_done(0, 40);

    repeat (3) @(negedge iclk);
    for (int i = 0; i < NI; i++) chk($sformatf("i%0d_queue_empty", i), 64'(exp_q[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
